mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter MEM_LATENCY, default 1 (range 1..15): cycles from the mem_en cycle to the cycle mem_rdata is valid.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req / if_addr / if_wdata / if_we  input  1/32/32/1  fetch requester; if_we is normally 0.
REQ-005 if_gnt / if_rvalid / if_rdata  output  1/1/32  fetch grant pulse, completion pulse, read data.
REQ-006 d_req / d_addr / d_wdata / d_we  input  1/32/32/1  data (load/store) requester.
REQ-007 d_gnt / d_rvalid / d_rdata  output  1/1/32  data grant pulse, completion pulse, read data.
REQ-008 mem_en / mem_we / mem_addr / mem_wdata  output  1/1/32/32  single shared memory port.
REQ-009 mem_rdata  input  32  memory read data.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL use the FSM IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
REQ-012 IDLE: with any req high, pick the winner, latch its addr/wdata/we and owner id, go to ACCESS; no req: stay.
REQ-013 ACCESS (1 cycle): mem_en=1, mem_we/addr/wdata from latched values, owner gnt=1; load latency counter with MEM_LATENCY; go to WAIT.
REQ-014 WAIT: lasts exactly MEM_LATENCY cycles; on its last cycle capture mem_rdata into the owner's rdata register (reads only); go to DONE.
REQ-015 DONE (1 cycle): owner rvalid=1 for reads and writes alike; go to IDLE.
REQ-016 Read latency from req first seen in IDLE to rvalid SHALL be MEM_LATENCY+2 cycles; next arbitration occurs in the following IDLE cycle.
REQ-017 gnt and rvalid SHALL be single-cycle pulses, only to the owner; the other port's gnt/rvalid SHALL stay 0.
REQ-018 if_rdata/d_rdata SHALL hold their last captured value until the next read completion on that port; writes leave them unchanged.
REQ-019 Requesters hold req/addr/wdata/we stable until gnt; changes after the IDLE-cycle latch SHALL be ignored.
REQ-020 mem_en SHALL be 0 outside ACCESS; mem_we SHALL be 0 whenever mem_en is 0.
REQ-021 Default arbitration (round-robin): when both req are high, grant the port not granted last; a single requester always wins.
REQ-022 A req dropped before being granted SHALL be ignored without side effects.

Reset
REQ-023 On reset: state IDLE; all gnt, rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; last-granted = data (fetch wins the first tie).
REQ-024 Reset asserted mid-transaction SHALL abandon it: no gnt/rvalid pulse afterwards, mem_en low from the next edge.

Configuration
REQ-025 With DATA_PRIORITY_EN defined, d_req SHALL always beat if_req when both are high (fixed priority) and the last-granted bit is unused; undefined: round-robin per REQ-021.

Structure
REQ-026 The shared package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, WAIT, DONE), the owner id constants (OWN_IF=0, OWN_D=1) and the latency counter width.
REQ-027 The winner selection SHALL be a sub-module arb_pick: inputs if_req, d_req, last; output owner id; combinational. The rest of the block is flat.

Verification
REQ-028 MEM_LATENCY=1, if_req only, addr 0x0, mem returns 0x002081B3 -> if_gnt at cycle 1, if_rvalid at cycle 3, if_rdata=0x002081B3, d_* pulses never assert.
REQ-029 Both req high from reset with addr 0x4 / 0x100, held until granted -> fetch served first, then data; round-robin alternates IF, D, IF, D over 4 back-to-back transactions.
REQ-030 DATA_PRIORITY_EN defined, both req held high -> d_gnt every transaction, if_gnt never.
REQ-031 d_we=1, d_addr 0x10, d_wdata 0xDEADBEEF -> mem_en=mem_we=1 for exactly 1 cycle with those values; d_rvalid pulses; d_rdata unchanged.
REQ-032 MEM_LATENCY=3, read in flight, reset raised in WAIT -> busy=0 and mem_en=0 on the next edge, no rvalid pulse; a new if_req then completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Wide enough for the maximum MEM_LATENCY of 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// DATA_PRIORITY_EN selects fixed data-first priority instead of round-robin.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last,
  output logic owner
);

  always_comb begin
`ifdef DATA_PRIORITY_EN
    owner = d_req ? OWN_D : OWN_IF;
`else
    if (if_req && d_req) owner = (last == OWN_D) ? OWN_IF : OWN_D;
    else                 owner = d_req ? OWN_D : OWN_IF;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single fixed-latency memory port.
// Optional macro DATA_PRIORITY_EN: data requester always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [31:0] if_wdata,
  input  logic        if_we,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_t            state, nxt;
  logic              owner_q, last_q, pick;
  logic [31:0]       addr_q, wdata_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              wait_last;

  arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .last   (last_q),
    .owner  (pick)
  );

  assign wait_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= OWN_IF;
      last_q   <= OWN_D;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cnt      <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (if_req || d_req) begin
          owner_q <= pick;
          last_q  <= pick;
          addr_q  <= (pick == OWN_D) ? d_addr  : if_addr;
          wdata_q <= (pick == OWN_D) ? d_wdata : if_wdata;
          we_q    <= (pick == OWN_D) ? d_we    : if_we;
        end
        ACCESS: cnt <= LAT;
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Capture on the final latency cycle; writes leave rdata untouched.
          if (wait_last && !we_q) begin
            if (owner_q == OWN_D) d_rdata  <= mem_rdata;
            else                  if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:   if (if_req || d_req) nxt = ACCESS;
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        if_gnt = (owner_q == OWN_IF);
        d_gnt  = (owner_q == OWN_D);
        nxt    = WAIT;
      end
      WAIT:   if (wait_last) nxt = DONE;
      DONE: begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut1 (MEM_LATENCY=1) and dut3 (MEM_LATENCY=3) share stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 0, if_we = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, if_wdata = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_wdata(if_wdata), .if_we(if_we),
    .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_wdata(if_wdata), .if_we(if_we),
    .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_d;
    logic [31:0] exp_if, exp_dr, val;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en1}, 32'd0);
    chk("rst_gnt", {30'd0, if_gnt1, d_gnt1}, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid1, d_rvalid1}, 32'd0);
    chk("rst_mem_addr", mem_addr1, 32'd0);
    chk("rst_mem_wdata", mem_wdata1, 32'd0);
    chk("rst_if_rdata", if_rdata1, 32'd0);
    chk("rst_d_rdata", d_rdata1, 32'd0);
    reset = 1'b0;

    // Single fetch read, latency 1
    if_req = 1; if_addr = 32'h0; mem_rdata = 32'h002081B3;
    tick();
    chk("t1_if_gnt_c1", {31'd0, if_gnt1}, 32'd1);
    chk("t1_mem_en_c1", {31'd0, mem_en1}, 32'd1);
    chk("t1_mem_we_c1", {31'd0, mem_we1}, 32'd0);
    chk("t1_mem_addr_c1", mem_addr1, 32'h0);
    chk("t1_d_pulses_c1", {30'd0, d_gnt1, d_rvalid1}, 32'd0);
    if_req = 0;
    tick();
    chk("t1_c2_quiet", {29'd0, if_gnt1, if_rvalid1, mem_en1}, 32'd0);
    chk("t1_c2_busy", {31'd0, busy1}, 32'd1);
    tick();
    chk("t1_if_rvalid_c3", {31'd0, if_rvalid1}, 32'd1);
    chk("t1_if_rdata", if_rdata1, 32'h002081B3);
    chk("t1_d_pulses_c3", {30'd0, d_gnt1, d_rvalid1}, 32'd0);
    tick();
    chk("t1_idle", {30'd0, busy1, if_rvalid1}, 32'd0);

    // Both requesters held high: four back-to-back transactions
    reset = 1; tick(); reset = 0;
    exp_if = 32'd0; exp_dr = 32'd0;
    if_req = 1; if_addr = 32'h4; d_req = 1; d_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_PRIORITY_EN
      exp_d = 1'b1;
`else
      exp_d = (i % 2 == 1);
`endif
      tick();
      chk($sformatf("rr%0d_gnt", i), {30'd0, if_gnt1, d_gnt1}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_addr", i), mem_addr1, exp_d ? 32'h100 : 32'h4);
      val = 32'h1000 + i;
      mem_rdata = val;
      tick();
      tick();
      if (exp_d) exp_dr = val; else exp_if = val;
      chk($sformatf("rr%0d_rvalid", i), {30'd0, if_rvalid1, d_rvalid1}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_if_rdata", i), if_rdata1, exp_if);
      chk($sformatf("rr%0d_d_rdata", i), d_rdata1, exp_dr);
      tick();
    end
    if_req = 0; d_req = 0;

    // Data read to seed d_rdata, then a data write
    reset = 1; tick(); reset = 0;
    d_req = 1; d_we = 0; d_addr = 32'h30;
    tick();
    d_req = 0; mem_rdata = 32'hCAFEF00D;
    tick(); tick();
    chk("wr_seed_d_rdata", d_rdata1, 32'hCAFEF00D);
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_mem_en_we", {30'd0, mem_en1, mem_we1}, 32'd3);
    chk("wr_mem_addr", mem_addr1, 32'h10);
    chk("wr_mem_wdata", mem_wdata1, 32'hDEADBEEF);
    chk("wr_d_gnt", {30'd0, if_gnt1, d_gnt1}, 32'd1);
    d_req = 0; d_we = 0; mem_rdata = 32'h12345678;
    tick();
    chk("wr_c2_mem_off", {30'd0, mem_en1, mem_we1}, 32'd0);
    tick();
    chk("wr_d_rvalid", {30'd0, if_rvalid1, d_rvalid1}, 32'd1);
    chk("wr_d_rdata_kept", d_rdata1, 32'hCAFEF00D);
    tick();

    // Latency 3: reset during WAIT abandons the read
    reset = 1; tick(); reset = 0;
    if_req = 1; if_addr = 32'h20; mem_rdata = 32'h11111111;
    tick();
    chk("rs_if_gnt", {31'd0, if_gnt3}, 32'd1);
    if_req = 0;
    tick(); tick();
    chk("rs_in_wait", {30'd0, busy3, mem_en3}, 32'd2);
    reset = 1;
    tick();
    chk("rs_after_reset", {28'd0, busy3, mem_en3, if_rvalid3, if_gnt3}, 32'd0);
    chk("rs_if_rdata", if_rdata3, 32'd0);
    reset = 0;
    tick();
    chk("rs_quiet1", {29'd0, busy3, if_rvalid3, if_gnt3}, 32'd0);
    tick();
    chk("rs_quiet2", {29'd0, busy3, if_rvalid3, if_gnt3}, 32'd0);
    if_req = 1; if_addr = 32'h24; mem_rdata = 32'hA5A5A5A5;
    tick();
    chk("rs_new_gnt", {31'd0, if_gnt3}, 32'd1);
    chk("rs_new_addr", mem_addr3, 32'h24);
    if_req = 0;
    tick(); tick(); tick();
    chk("rs_c4_no_rvalid", {31'd0, if_rvalid3}, 32'd0);
    tick();
    chk("rs_c5_rvalid", {30'd0, if_rvalid3, d_rvalid3}, 32'd2);
    chk("rs_c5_rdata", if_rdata3, 32'hA5A5A5A5);
    tick();
    chk("rs_idle", {31'd0, busy3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
